lsu_ctrl: RTL and testbench

- Sequences every data-memory access issued by the execute stage's load/store unit.
- Accepts one load/store request at a time over a valid/ready handshake and checks its alignment.
- Drives the data-memory request/grant/response bus with word-aligned address, byte enables and lane-replicated write data.
- Returns byte/half/word-extracted, sign- or zero-extended load data to writeback, or raises a misaligned/access-fault exception instead.

---
 rtl/lsu_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit data-memory access sequencer
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [XLEN-1:0] req_adr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [2:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_adr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic            dmem_err_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic [4:0]      rsp_rd_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_tval_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] adr_q, adr_d, wdata_q, wdata_d;
  logic [2:0]      size_q, size_d;
  logic            store_q, store_d, uns_q, uns_d, kill_q, kill_d;
  logic [4:0]      rd_q, rd_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d, exc_valid_q, exc_valid_d, exc_mis_q, exc_mis_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d, exc_tval_q, exc_tval_d;
  logic [4:0]      rsp_rd_q, rsp_rd_d;
  logic [3:0]      exc_cause_q, exc_cause_d;

  logic            accept, misalign;
  logic [XLEN-1:0] lane, ld_data;

  assign req_ready_o  = (state_q == IDLE) && !flush_i;
  assign accept       = req_valid_i && req_ready_o;
  assign busy_o       = (state_q != IDLE);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = store_q;
  assign dmem_adr_o   = {adr_q[XLEN-1:2], 2'b00};
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_rd_o     = rsp_rd_q;
  // A flush arriving while a misalign exception is being presented cancels it.
  assign exc_valid_o  = exc_valid_q && !(exc_mis_q && flush_i);
  assign exc_cause_o  = exc_cause_q;
  assign exc_tval_o   = exc_tval_q;

  always_comb begin
    misalign = 1'b1;
    case (req_size_i)
      3'b001:  misalign = 1'b0;
      3'b010:  misalign = req_adr_i[0];
      3'b100:  misalign = |req_adr_i[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = '0;
    if (size_q[0]) begin
      dmem_be_o    = 4'b0001 << adr_q[1:0];
      dmem_wdata_o = {4{wdata_q[7:0]}};
    end else if (size_q[1]) begin
      dmem_be_o    = 4'b0011 << adr_q[1:0];
      dmem_wdata_o = {2{wdata_q[15:0]}};
    end else if (size_q[2]) begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = wdata_q;
    end
  end

  always_comb begin
    lane    = dmem_rdata_i >> {adr_q[1:0], 3'b000};
    ld_data = lane;
    if (size_q[0])
      ld_data = {{(XLEN-8){~uns_q & lane[7]}}, lane[7:0]};
    else if (size_q[1])
      ld_data = {{(XLEN-16){~uns_q & lane[15]}}, lane[15:0]};
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    store_d     = store_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    kill_d      = kill_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    exc_valid_d = 1'b0;
    exc_mis_d   = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_tval_d  = exc_tval_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d   = req_adr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          store_d = req_store_i;
          uns_d   = req_unsigned_i;
          rd_d    = req_rd_i;
          kill_d  = 1'b0;
          if (misalign) begin
            exc_valid_d = 1'b1;
            exc_mis_d   = 1'b1;
            exc_cause_d = {2'b01, req_store_i, 1'b0};
            exc_tval_d  = req_adr_i;
          end else begin
            state_d = REQ;
            cnt_d   = 8'd0;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = WAIT;
          kill_d  = flush_i;
          cnt_d   = cnt_q + 8'd1;
        end else if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q >= TO_LAST) begin
          state_d     = IDLE;
          exc_valid_d = 1'b1;
          exc_cause_d = {2'b01, store_q, 1'b1};
          exc_tval_d  = adr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (flush_i)
          kill_d = 1'b1;
        if (dmem_rvalid_i || cnt_q >= TO_LAST) begin
          state_d = IDLE;
          if (!(kill_q || flush_i)) begin
            if (!dmem_rvalid_i || dmem_err_i) begin
              exc_valid_d = 1'b1;
              exc_cause_d = {2'b01, store_q, 1'b1};
              exc_tval_d  = adr_q;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_rd_d    = rd_q;
              rsp_data_d  = store_q ? '0 : ld_data;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_mis_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      store_q     <= store_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      exc_valid_q <= exc_valid_d;
      exc_mis_q   <= exc_mis_d;
      exc_cause_q <= exc_cause_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_i, req_ready_o, req_store_i, req_unsigned_i, flush_i;
  logic [31:0] req_adr_i, req_wdata_i;
  logic [2:0]  req_size_i;
  logic [4:0]  req_rd_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_adr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        rsp_valid_o, exc_valid_o, busy_o;
  logic [31:0] rsp_data_o, exc_tval_o;
  logic [4:0]  rsp_rd_o;
  logic [3:0]  exc_cause_o;

  typedef struct packed {
    logic        exc;
    logic [31:0] val;
    logic [31:0] aux;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_adr_o(dmem_adr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every completion or exception pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && (rsp_valid_o || exc_valid_o)) begin
      chk("one_pulse", 32'(rsp_valid_o & exc_valid_o), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_evt", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("evt_kind", 32'(exc_valid_o), 32'(e.exc));
        if (e.exc) begin
          chk("exc_cause", 32'(exc_cause_o), e.val);
          chk("exc_tval", exc_tval_o, e.aux);
        end else begin
          chk("rsp_data", rsp_data_o, e.val);
          chk("rsp_rd", 32'(rsp_rd_o), e.aux);
        end
      end
    end
  end

  task automatic push(input logic exc, input logic [31:0] val, input logic [31:0] aux);
    sb.push_back('{exc: exc, val: val, aux: aux});
  endtask

  task automatic issue(input logic st, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [2:0] sz, input logic un, input logic [4:0] rd);
    chk("ready_before_issue", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_store_i = st; req_adr_i = adr; req_wdata_i = wd;
    req_size_i = sz; req_unsigned_i = un; req_rd_i = rd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  // Withhold grant for gdly cycles, checking the request stays stable, then respond.
  task automatic bus(input int gdly, input logic [31:0] adr, input logic [3:0] be,
                     input logic [31:0] wd, input logic we,
                     input logic [31:0] rdata, input logic err);
    for (int i = 0; i <= gdly; i++) begin
      if (i == gdly) dmem_gnt_i = 1'b1;
      @(negedge clk);
      chk("dmem_req", 32'(dmem_req_o), 32'd1);
      chk("dmem_adr", dmem_adr_o, adr);
      chk("dmem_be", 32'(dmem_be_o), 32'(be));
      chk("dmem_wdata", dmem_wdata_o, wd);
      chk("dmem_we", 32'(dmem_we_o), 32'(we));
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; dmem_err_i = err;
    @(negedge clk);
    chk("dmem_req_drop", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; req_valid_i = 0; req_store_i = 0; req_adr_i = 0; req_wdata_i = 0;
    req_size_i = 0; req_unsigned_i = 0; req_rd_i = 0; flush_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0; dmem_err_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_adr", dmem_adr_o, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid_o), 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // signed byte load from top lane, latency check
    push(1'b0, 32'hFFFF_FF80, 32'd5);
    issue(1'b0, 32'h1003, 32'h0, 3'b001, 1'b0, 5'd5);
    bus(0, 32'h1000, 4'b1000, 32'h0, 1'b0, 32'h8012_3456, 1'b0);
    @(negedge clk);
    chk("t3_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("t3_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // half store, lane replicated
    push(1'b0, 32'h0, 32'd7);
    issue(1'b1, 32'h2002, 32'h0000_BEEF, 3'b010, 1'b0, 5'd7);
    bus(0, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'hDEAD_0000, 1'b0);
    repeat (2) @(posedge clk); #1;

    // misaligned word load
    push(1'b1, 32'd4, 32'h3001);
    issue(1'b0, 32'h3001, 32'h0, 3'b100, 1'b0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis_no_req", 32'(dmem_req_o), 32'd0);
      chk("mis_not_busy", 32'(busy_o), 32'd0);
    end
    @(posedge clk); #1;

    // non-one-hot size on a store is treated as misaligned
    push(1'b1, 32'd6, 32'h40);
    issue(1'b1, 32'h40, 32'h1, 3'b011, 1'b0, 5'd4);
    repeat (2) @(posedge clk); #1;

    // grant withheld 5 cycles, store bus error
    push(1'b1, 32'd7, 32'h4008);
    issue(1'b1, 32'h4008, 32'h1234_5678, 3'b100, 1'b0, 5'd9);
    bus(5, 32'h4008, 4'b1111, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    repeat (2) @(posedge clk); #1;

    // signed half load from upper lane
    push(1'b0, 32'hFFFF_8001, 32'd2);
    issue(1'b0, 32'h6002, 32'h0, 3'b010, 1'b0, 5'd2);
    bus(1, 32'h6000, 4'b1100, 32'h0, 1'b0, 32'h8001_1234, 1'b0);
    repeat (2) @(posedge clk); #1;

    // timeout with no grant, then a stray rvalid
    push(1'b1, 32'd5, 32'h5000);
    issue(1'b0, 32'h5000, 32'h0, 3'b100, 1'b0, 5'd11);
    n = 0;
    @(negedge clk);
    while (dmem_req_o === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(n), 32'd255);
    chk("timeout_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    repeat (3) @(posedge clk); #1;

    // flush in REQ before grant
    issue(1'b0, 32'h20, 32'h0, 3'b001, 1'b1, 5'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_req_drop", 32'(dmem_req_o), 32'd0);
    chk("flush_req_idle", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk); #1;

    // flush during WAIT kills the LHU response
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 5'd12);
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_F00D;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("flush_wait_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;

    // same access unflushed
    push(1'b0, 32'h0000_F00D, 32'd12);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 5'd12);
    bus(0, 32'h10, 4'b0011, 32'h0, 1'b0, 32'h0000_F00D, 1'b0);
    repeat (3) @(posedge clk); #1;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
